// File: rtl/eth_pcs_rx_link_ctrl.sv
// 10GBASE-R style receive link monitor: windows sync-header errors, walks the
// LINK_DOWN/BER_CHECK/LINK_UP/HI_BER/RESYNC states and keeps an error counter.
module eth_pcs_rx_link_ctrl #(
  parameter int BER_TIMER_CYC = 195313,
  parameter int BER_BAD_MAX   = 16,
  parameter int LINK_UP_WIN   = 4,
  parameter int HI_BER_RESYNC = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hdr_valid,
  input  logic [1:0] i_hdr,
  input  logic       i_rx_lock,
  input  logic       i_ber_cnt_clr,
  output logic       o_link_up,
  output logic       o_hi_ber,
  output logic       o_resync,
  output logic [5:0] o_ber_cnt
);

  localparam int TW = (BER_TIMER_CYC > 1) ? $clog2(BER_TIMER_CYC) : 1;
  localparam int BW = $clog2(BER_BAD_MAX + 1);
  localparam int GW = $clog2(LINK_UP_WIN + 1);
  localparam int HW = $clog2(HI_BER_RESYNC + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(BER_TIMER_CYC - 1);
  localparam logic [BW-1:0] BAD_MAX   = BW'(BER_BAD_MAX);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LINK_UP_WIN - 1);
  localparam logic [HW-1:0] HI_LAST   = HW'(HI_BER_RESYNC - 1);

  typedef enum logic [2:0] {LINK_DOWN, BER_CHECK, LINK_UP, HI_BER, RESYNC} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [BW-1:0] bad_cnt;
  logic [GW-1:0] good_cnt;
  logic [HW-1:0] hi_cnt;
  logic [5:0]    ber_cnt;

  logic          inv;
  logic          win_end;
  logic          win_bad;
  logic [BW-1:0] bad_nxt;

  // Window-bad includes the header arriving this cycle.
  always_comb begin
    inv     = i_hdr_valid && (i_hdr == 2'b00 || i_hdr == 2'b11);
    win_end = (timer == T_LAST);
    bad_nxt = (bad_cnt == BAD_MAX) ? BAD_MAX : bad_cnt + BW'(inv);
    win_bad = (bad_nxt == BAD_MAX);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= LINK_DOWN;
      timer    <= '0;
      bad_cnt  <= '0;
      good_cnt <= '0;
      hi_cnt   <= '0;
      ber_cnt  <= '0;
    end else begin
      if (i_ber_cnt_clr)
        ber_cnt <= 6'(inv && i_rx_lock);
      else if (inv && i_rx_lock && ber_cnt != 6'd63)
        ber_cnt <= ber_cnt + 6'd1;

      case (state)
        LINK_DOWN: begin
          timer   <= '0;
          bad_cnt <= '0;
          if (i_rx_lock) begin
            state    <= BER_CHECK;
            good_cnt <= '0;
            hi_cnt   <= '0;
          end
        end
        RESYNC: begin
          state   <= LINK_DOWN;
          timer   <= '0;
          bad_cnt <= '0;
        end
        default: begin
          if (!i_rx_lock) begin
            state    <= LINK_DOWN;
            timer    <= '0;
            bad_cnt  <= '0;
            good_cnt <= '0;
            hi_cnt   <= '0;
          end else begin
            timer   <= win_end ? '0 : timer + 1'b1;
            bad_cnt <= win_end ? '0 : bad_nxt;
            case (state)
              BER_CHECK: begin
                if (win_bad) begin
                  state  <= HI_BER;
                  hi_cnt <= '0;
                end else if (win_end) begin
                  good_cnt <= good_cnt + 1'b1;
                  if (good_cnt == GOOD_LAST) state <= LINK_UP;
                end
              end
              LINK_UP: begin
                if (win_bad) begin
                  state  <= HI_BER;
                  hi_cnt <= '0;
                end
              end
              HI_BER: begin
                if (win_end) begin
                  if (win_bad) begin
                    hi_cnt <= hi_cnt + 1'b1;
                    if (hi_cnt == HI_LAST) state <= RESYNC;
                  end else begin
                    state    <= BER_CHECK;
                    good_cnt <= '0;
                    hi_cnt   <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign o_link_up = (state == LINK_UP);
  assign o_hi_ber  = (state == HI_BER);
  assign o_resync  = (state == RESYNC);
  assign o_ber_cnt = ber_cnt;

endmodule

// File: tb/tb_eth_pcs_rx_link_ctrl.sv
// Directed bench for eth_pcs_rx_link_ctrl with short windows (64 cycles, 4 bad,
// 2 good windows, 3 hi-BER windows); expected cycle counts are hand-derived.
module tb_eth_pcs_rx_link_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hv = 1'b0;
  logic [1:0] hdr = 2'b01;
  logic       lock = 1'b0;
  logic       clr = 1'b0;
  logic       link_up, hi_ber, resync;
  logic [5:0] ber_cnt;
  int         vecs = 0;
  int         errs = 0;

  always #5 clk = ~clk;

  eth_pcs_rx_link_ctrl #(
    .BER_TIMER_CYC(64), .BER_BAD_MAX(4), .LINK_UP_WIN(2), .HI_BER_RESYNC(3)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_hdr_valid(hv), .i_hdr(hdr),
    .i_rx_lock(lock), .i_ber_cnt_clr(clr),
    .o_link_up(link_up), .o_hi_ber(hi_ber), .o_resync(resync), .o_ber_cnt(ber_cnt)
  );

  // Apply one cycle of inputs; outputs are then read 1ns after the edge.
  task automatic tick(input logic v, input logic [1:0] h, input logic l, input logic c);
    hv = v; hdr = h; lock = l; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL reset_link_up got %b want 0", link_up); end
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL reset_hi_ber got %b want 0", hi_ber); end
    vecs++; if (resync !== 1'b0) begin errs++; $display("FAIL reset_resync got %b want 0", resync); end
    vecs++; if (ber_cnt !== 6'd0) begin errs++; $display("FAIL reset_ber_cnt got %0d want 0", ber_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_link_up();
    int n = 0;
    bit seen_hi = 0;
    tick(1'b1, 2'b01, 1'b1, 1'b0);
    while (link_up !== 1'b1 && n < 300) begin
      tick(1'b1, 2'b01, 1'b1, 1'b0);
      n++;
      if (hi_ber !== 1'b0) seen_hi = 1;
    end
    vecs++; if (n != 128) begin errs++; $display("FAIL link_up_latency got %0d want 128", n); end
    vecs++; if (seen_hi) begin errs++; $display("FAIL link_up_hi_ber got 1 want 0"); end
  endtask

  task automatic test_hi_ber();
    repeat (3) tick(1'b1, 2'b11, 1'b1, 1'b0);
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL hi_ber_early got %b want 0", hi_ber); end
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    vecs++; if (hi_ber !== 1'b1) begin errs++; $display("FAIL hi_ber_set got %b want 1", hi_ber); end
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL hi_ber_link_up got %b want 0", link_up); end
    vecs++; if (ber_cnt !== 6'd4) begin errs++; $display("FAIL hi_ber_cnt got %0d want 4", ber_cnt); end
  endtask

  // HI_BER was entered at timer 4: 60 cycles finish the entry window, then 2 more windows.
  task automatic test_resync();
    int n = 0;
    while (resync !== 1'b1 && n < 400) begin
      tick(1'b1, 2'b00, 1'b1, 1'b0);
      n++;
    end
    vecs++; if (n != 188) begin errs++; $display("FAIL resync_latency got %0d want 188", n); end
    vecs++; if (ber_cnt !== 6'd63) begin errs++; $display("FAIL resync_ber_cnt got %0d want 63", ber_cnt); end
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL resync_hi_ber got %b want 0", hi_ber); end
    tick(1'b1, 2'b00, 1'b1, 1'b0);
    vecs++; if (resync !== 1'b0) begin errs++; $display("FAIL resync_pulse got %b want 0", resync); end
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL resync_link_up got %b want 0", link_up); end
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL resync_then_down got %b want 0", hi_ber); end
  endtask

  // Entry window is already bad (count 1); one clean window then exits to BER_CHECK.
  task automatic test_recover();
    int n = 0;
    reset = 1'b1;
    tick(1'b0, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    tick(1'b1, 2'b01, 1'b1, 1'b0);
    repeat (128) tick(1'b1, 2'b01, 1'b1, 1'b0);
    vecs++; if (link_up !== 1'b1) begin errs++; $display("FAIL recover_link_up got %b want 1", link_up); end
    repeat (4) tick(1'b1, 2'b11, 1'b1, 1'b0);
    vecs++; if (hi_ber !== 1'b1) begin errs++; $display("FAIL recover_hi_ber got %b want 1", hi_ber); end
    while (hi_ber === 1'b1 && n < 300) begin
      tick(1'b1, 2'b01, 1'b1, 1'b0);
      n++;
    end
    vecs++; if (n != 124) begin errs++; $display("FAIL recover_exit got %0d want 124", n); end
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL recover_check_state got %b want 0", link_up); end
    n = 0;
    while (link_up !== 1'b1 && n < 300) begin
      tick(1'b1, 2'b01, 1'b1, 1'b0);
      n++;
    end
    vecs++; if (n != 128) begin errs++; $display("FAIL recover_relink got %0d want 128", n); end
  endtask

  task automatic test_lock_drop();
    tick(1'b1, 2'b11, 1'b1, 1'b1);
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    vecs++; if (link_up !== 1'b1) begin errs++; $display("FAIL drop_pre_link_up got %b want 1", link_up); end
    vecs++; if (ber_cnt !== 6'd3) begin errs++; $display("FAIL drop_pre_cnt got %0d want 3", ber_cnt); end
    tick(1'b1, 2'b11, 1'b0, 1'b0);
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL drop_link_up got %b want 0", link_up); end
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL drop_hi_ber got %b want 0", hi_ber); end
    vecs++; if (ber_cnt !== 6'd3) begin errs++; $display("FAIL drop_cnt got %0d want 3", ber_cnt); end
    tick(1'b1, 2'b01, 1'b0, 1'b0);
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL drop_stay_down got %b want 0", hi_ber); end
  endtask

  task automatic test_ber_sat();
    tick(1'b0, 2'b01, 1'b1, 1'b1);
    vecs++; if (ber_cnt !== 6'd0) begin errs++; $display("FAIL sat_clear got %0d want 0", ber_cnt); end
    repeat (70) tick(1'b1, 2'b00, 1'b1, 1'b0);
    vecs++; if (ber_cnt !== 6'd63) begin errs++; $display("FAIL sat_max got %0d want 63", ber_cnt); end
    tick(1'b1, 2'b11, 1'b1, 1'b1);
    vecs++; if (ber_cnt !== 6'd1) begin errs++; $display("FAIL sat_clr_and_bad got %0d want 1", ber_cnt); end
  endtask

  task automatic test_reset_mid();
    vecs++; if (hi_ber !== 1'b1) begin errs++; $display("FAIL mid_pre_hi_ber got %b want 1", hi_ber); end
    reset = 1'b1;
    tick(1'b1, 2'b11, 1'b1, 1'b0);
    reset = 1'b0;
    vecs++; if (hi_ber !== 1'b0) begin errs++; $display("FAIL mid_hi_ber got %b want 0", hi_ber); end
    vecs++; if (link_up !== 1'b0) begin errs++; $display("FAIL mid_link_up got %b want 0", link_up); end
    vecs++; if (resync !== 1'b0) begin errs++; $display("FAIL mid_resync got %b want 0", resync); end
    vecs++; if (ber_cnt !== 6'd0) begin errs++; $display("FAIL mid_ber_cnt got %0d want 0", ber_cnt); end
  endtask

  initial begin
    test_reset();
    test_link_up();
    test_hi_ber();
    test_resync();
    test_recover();
    test_lock_drop();
    test_ber_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
